// File: rtl/time_sync_scheduler.sv
// time_sync_scheduler: periodic/manual host time sync with timeout, retries and a commit to the time counter.
// Define TIME_SYNC_RANGE_CHECK_EN to reject out-of-range host time in VALIDATE.
module time_sync_scheduler #(
    parameter int SYNC_PERIOD    = 3600,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sec_tick,
    input  logic       manual_sync,
    input  logic       edit_active,
    output logic       sync_request,
    input  logic       sync_done,
    input  logic [4:0] host_hr,
    input  logic [5:0] host_min,
    input  logic [5:0] host_sec,
    output logic       load,
    output logic [4:0] load_hr,
    output logic [5:0] load_min,
    output logic [5:0] load_sec,
    output logic       busy,
    output logic       sync_ok,
    output logic       sync_fail,
    output logic [7:0] fail_count
);
    localparam int PW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PLAST = PW'(SYNC_PERIOD - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RLAST = 4'(MAX_RETRY - 1);

    typedef enum logic [2:0] {IDLE, REQUEST, WAIT_DONE, VALIDATE, COMMIT} state_t;

    state_t        state, state_next;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] timer;
    logic [3:0]    attempts;
    logic          pending;
    logic [4:0]    cap_hr;
    logic [5:0]    cap_min, cap_sec;
    logic          range_ok, attempt_fail, give_up, abort, wrap;

`ifdef TIME_SYNC_RANGE_CHECK_EN
    assign range_ok = (cap_hr <= 5'd23) && (cap_min <= 6'd59) && (cap_sec <= 6'd59);
`else
    assign range_ok = 1'b1;
`endif

    always_comb begin
        state_next   = state;
        attempt_fail = 1'b0;
        case (state)
            IDLE:      if (pending && !edit_active) state_next = REQUEST;
            REQUEST:   state_next = WAIT_DONE;
            // a done arriving in the timeout cycle still wins
            WAIT_DONE: if (sync_done) state_next = VALIDATE;
                       else if (timer == TLAST) attempt_fail = 1'b1;
            VALIDATE:  if (edit_active) state_next = IDLE;
                       else if (!range_ok) attempt_fail = 1'b1;
                       else state_next = COMMIT;
            COMMIT:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (attempt_fail) state_next = (attempts == RLAST) ? IDLE : REQUEST;
    end

    assign give_up = attempt_fail && (attempts == RLAST);
    assign abort   = (state == VALIDATE) && edit_active;
    assign wrap    = sec_tick && (period_cnt == PLAST) && (state != COMMIT);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            period_cnt <= '0;
            timer      <= '0;
            attempts   <= '0;
            pending    <= 1'b0;
            cap_hr     <= '0;
            cap_min    <= '0;
            cap_sec    <= '0;
            load_hr    <= '0;
            load_min   <= '0;
            load_sec   <= '0;
            sync_fail  <= 1'b0;
            fail_count <= '0;
        end else begin
            state <= state_next;
            if (state == COMMIT) period_cnt <= '0;
            else if (sec_tick) period_cnt <= (period_cnt == PLAST) ? '0 : period_cnt + 1'b1;
            // a new trigger in the same cycle as a clear is kept
            if (manual_sync || wrap || abort) pending <= 1'b1;
            else if (state == REQUEST || state == COMMIT) pending <= 1'b0;
            if (state == REQUEST) timer <= '0;
            else if (state == WAIT_DONE) timer <= timer + 1'b1;
            if (state == COMMIT || abort || give_up) attempts <= '0;
            else if (attempt_fail) attempts <= attempts + 4'd1;
            if (state == WAIT_DONE && sync_done) begin
                cap_hr  <= host_hr;
                cap_min <= host_min;
                cap_sec <= host_sec;
            end
            if (state_next == COMMIT) begin
                load_hr  <= cap_hr;
                load_min <= cap_min;
                load_sec <= cap_sec;
            end
            sync_fail <= give_up;
            if (give_up && fail_count != 8'hff) fail_count <= fail_count + 8'd1;
        end
    end

    assign sync_request = (state == REQUEST);
    assign load         = (state == COMMIT);
    assign sync_ok      = (state == COMMIT);
    assign busy         = (state != IDLE);
endmodule

// File: tb/tb_time_sync_scheduler.sv
// tb_time_sync_scheduler: directed bench for time_sync_scheduler (SYNC_PERIOD=5, TIMEOUT_CYCLES=8, MAX_RETRY=3).
// Honours TIME_SYNC_RANGE_CHECK_EN when choosing expectations for the out-of-range host time.
module tb_time_sync_scheduler;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       sec_tick = 1'b0, manual_sync = 1'b0, edit_active = 1'b0, sync_done = 1'b0;
    logic [4:0] host_hr = '0;
    logic [5:0] host_min = '0, host_sec = '0;
    logic       sync_request, load, busy, sync_ok, sync_fail;
    logic [4:0] load_hr;
    logic [5:0] load_min, load_sec;
    logic [7:0] fail_count;
    logic [4:0] exp_hr;
    int checks = 0, failures = 0;

    time_sync_scheduler #(.SYNC_PERIOD(5), .TIMEOUT_CYCLES(8), .MAX_RETRY(3)) dut (
        .clock(clock), .reset_n(reset_n), .sec_tick(sec_tick), .manual_sync(manual_sync),
        .edit_active(edit_active), .sync_request(sync_request), .sync_done(sync_done),
        .host_hr(host_hr), .host_min(host_min), .host_sec(host_sec), .load(load),
        .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec), .busy(busy),
        .sync_ok(sync_ok), .sync_fail(sync_fail), .fail_count(fail_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic host(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        host_hr = h;
        host_min = m;
        host_sec = s;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_req", sync_request, 0);
        chk("rst_load", load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ok", sync_ok, 0);
        chk("rst_fail", sync_fail, 0);
        chk("rst_fcnt", fail_count, 0);
        chk("rst_hr", load_hr, 0);
        reset_n = 1'b1;
        tick();
        // stray done in IDLE is ignored
        host(1, 2, 3);
        sync_done = 1'b1;
        tick();
        sync_done = 1'b0;
        chk("stray_busy", busy, 0);
        tick();
        chk("stray_busy2", busy, 0);
        // manual sync, host answers 13:45:30
        manual_sync = 1'b1;
        tick();
        manual_sync = 1'b0;
        chk("man_req_t1", sync_request, 0);
        tick();
        chk("man_req_t2", sync_request, 1);
        tick();
        chk("man_req_end", sync_request, 0);
        chk("man_busy", busy, 1);
        repeat (4) tick();
        host(13, 45, 30);
        sync_done = 1'b1;
        tick();
        sync_done = 1'b0;
        chk("man_validate_load", load, 0);
        tick();
        chk("man_load", load, 1);
        chk("man_ok", sync_ok, 1);
        chk("man_hr", load_hr, 13);
        chk("man_min", load_min, 45);
        chk("man_sec", load_sec, 30);
        tick();
        chk("man_idle_busy", busy, 0);
        chk("man_idle_load", load, 0);
        chk("man_hold_hr", load_hr, 13);
        // periodic sync: fifth sec_tick triggers
        for (int i = 0; i < 4; i++) begin
            sec_tick = 1'b1;
            tick();
            sec_tick = 1'b0;
            chk("per_quiet_a", sync_request, 0);
            tick();
            chk("per_quiet_b", sync_request, 0);
        end
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        chk("per_pending_cycle", sync_request, 0);
        tick();
        chk("per_req1", sync_request, 1);
        tick();
        host(1, 2, 3);
        sync_done = 1'b1;
        tick();
        sync_done = 1'b0;
        tick();
        chk("per_load1", load, 1);
        chk("per_min1", load_min, 2);
        tick();
        for (int i = 0; i < 4; i++) begin
            sec_tick = 1'b1;
            tick();
            sec_tick = 1'b0;
            tick();
            chk("per_quiet_c", sync_request, 0);
        end
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        tick();
        chk("per_req2", sync_request, 1);
        tick();
        host(2, 3, 4);
        sync_done = 1'b1;
        tick();
        sync_done = 1'b0;
        tick();
        chk("per_load2", load, 1);
        chk("per_sec2", load_sec, 4);
        tick();
        // silent host: three requests 9 cycles apart, then one failure
        manual_sync = 1'b1;
        tick();
        manual_sync = 1'b0;
        tick();
        chk("to_req0", sync_request, 1);
        for (int k = 0; k < 2; k++) begin
            repeat (8) begin
                tick();
                chk("to_gap", sync_request, 0);
            end
            tick();
            chk("to_retry_req", sync_request, 1);
        end
        repeat (8) begin
            tick();
            chk("to_gap_last", sync_request, 0);
            chk("to_nofail_yet", sync_fail, 0);
        end
        tick();
        chk("to_fail", sync_fail, 1);
        chk("to_fcnt", fail_count, 1);
        chk("to_busy", busy, 0);
        chk("to_noload", load, 0);
        tick();
        chk("to_fail_pulse", sync_fail, 0);
        tick();
        chk("to_no_rerun", sync_request, 0);
        // out-of-range host time 24:00:00
        manual_sync = 1'b1;
        tick();
        manual_sync = 1'b0;
        tick();
        tick();
        host(24, 0, 0);
        sync_done = 1'b1;
        tick();
        sync_done = 1'b0;
`ifdef TIME_SYNC_RANGE_CHECK_EN
        tick();
        chk("rng_retry_req", sync_request, 1);
        chk("rng_noload", load, 0);
        tick();
        host(23, 59, 59);
        sync_done = 1'b1;
        tick();
        sync_done = 1'b0;
        tick();
        chk("rng_load", load, 1);
        chk("rng_hr", load_hr, 23);
        chk("rng_min", load_min, 59);
        chk("rng_sec", load_sec, 59);
        exp_hr = 5'd23;
`else
        tick();
        chk("rng_load", load, 1);
        chk("rng_hr", load_hr, 24);
        chk("rng_min", load_min, 0);
        chk("rng_sec", load_sec, 0);
        exp_hr = 5'd24;
`endif
        tick();
        chk("rng_fcnt", fail_count, 1);
        // edit during WAIT_DONE aborts, then reruns once released
        manual_sync = 1'b1;
        tick();
        manual_sync = 1'b0;
        tick();
        tick();
        edit_active = 1'b1;
        tick();
        tick();
        host(5, 6, 7);
        sync_done = 1'b1;
        tick();
        sync_done = 1'b0;
        chk("edit_validate_busy", busy, 1);
        tick();
        chk("edit_busy", busy, 0);
        chk("edit_noload", load, 0);
        chk("edit_nook", sync_ok, 0);
        chk("edit_nofail", sync_fail, 0);
        repeat (3) begin
            tick();
            chk("edit_hold_req", sync_request, 0);
            chk("edit_hold_busy", busy, 0);
        end
        edit_active = 1'b0;
        tick();
        chk("edit_rerun_req", sync_request, 1);
        chk("edit_hr_kept", load_hr, exp_hr);
        chk("edit_fcnt", fail_count, 1);
        // reset during WAIT_DONE
        tick();
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        chk("mrst_req", sync_request, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_load", load, 0);
        chk("mrst_fail", sync_fail, 0);
        chk("mrst_fcnt", fail_count, 0);
        chk("mrst_hr", load_hr, 0);
        chk("mrst_min", load_min, 0);
        chk("mrst_sec", load_sec, 0);
        reset_n = 1'b1;
        host(9, 9, 9);
        sync_done = 1'b1;
        tick();
        sync_done = 1'b0;
        repeat (3) begin
            tick();
            chk("mrst_done_noload", load, 0);
            chk("mrst_done_busy", busy, 0);
        end
        chk("mrst_hr_after", load_hr, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
